// File: rtl/count_sched_pkg.sv
// Shared types and default parameters for the count_sched request scheduler.
package count_sched_pkg;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  localparam int NREQ_DEF   = 4;
  localparam int PEND_W_DEF = 3;
  localparam int DIV1_DEF   = 4;

endpackage

// File: rtl/count_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request after i_last, modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);

  logic [LW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    w_idx   = i_last;
    for (int off = 0; off < N; off++) begin
      w_idx = (w_idx == LW'(N - 1)) ? '0 : w_idx + LW'(1);
      if (!o_valid && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// Request scheduler for the dual-channel prescaled event counter.
// Optional build macro COUNT_SCHED_PRIO_EN gives requester 0 fixed top priority.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int PEND_W = PEND_W_DEF,
  parameter int DIV1   = DIV1_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ-1:0] ChanMap,
  input  logic            Clear,
  output logic            CntReset,
  output logic            CntEn,
  output logic            CntSlt,
  output logic [NREQ-1:0] Grant,
  output logic            Tick1,
  output logic [NREQ-1:0] Overflow,
  output logic            Busy
);

  localparam int LG_W = $clog2(NREQ);
  localparam int PH_W = (DIV1 > 1) ? $clog2(DIV1) : 1;
  localparam logic [PH_W-1:0]   PH_MAX    = PH_W'(DIV1 - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [LG_W-1:0]   LAST_INIT = LG_W'(NREQ - 1);

  state_e            r_state, w_state_nxt;
  logic [PEND_W-1:0] r_pend [NREQ];
  logic [LG_W-1:0]   r_last;
  logic [PH_W-1:0]   r_ph;

  logic [NREQ-1:0] w_cand, w_arb_req, w_arb_gnt, w_gnt;
  logic            w_arb_valid, w_valid, w_upd_last, w_slt, w_any_pend;
  logic [LG_W-1:0] w_win;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  w_state_nxt = S_RUN;
      S_RUN:   if (Clear) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    w_cand     = '0;
    w_any_pend = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand[i]  = (r_pend[i] != '0);
      w_any_pend = w_any_pend | w_cand[i];
    end
  end

  assign Busy = (r_state != S_RUN) || w_any_pend;

  // Requester 0 bypasses the ring when prioritised, so its wins never move r_last.
  always_comb begin
`ifdef COUNT_SCHED_PRIO_EN
    w_arb_req  = w_cand & ~NREQ'(1);
    w_gnt      = w_cand[0] ? NREQ'(1) : w_arb_gnt;
    w_valid    = w_cand[0] | w_arb_valid;
    w_upd_last = !w_cand[0] && w_arb_valid;
`else
    w_arb_req  = w_cand;
    w_gnt      = w_arb_gnt;
    w_valid    = w_arb_valid;
    w_upd_last = w_arb_valid;
`endif
  end

  rr_arbiter #(.N(NREQ), .LW(LG_W)) u_arb (
    .i_req   (w_arb_req),
    .i_last  (r_last),
    .o_gnt   (w_arb_gnt),
    .o_valid (w_arb_valid)
  );

  always_comb begin
    w_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) w_win = LG_W'(i);
    end
  end

  assign w_slt = |(w_gnt & ChanMap);

  // CntEn is a one-cycle issue strobe; the counter accepts every issue, no back-pressure.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CntReset <= 1'b1;
      CntEn    <= 1'b0;
      CntSlt   <= 1'b0;
      Grant    <= '0;
      Tick1    <= 1'b0;
      Overflow <= '0;
      r_last   <= LAST_INIT;
      r_ph     <= '0;
      for (int i = 0; i < NREQ; i++) r_pend[i] <= '0;
    end else begin
      CntEn  <= 1'b0;
      CntSlt <= 1'b0;
      Grant  <= '0;
      Tick1  <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (Clear) begin
            CntReset <= 1'b1;
            Overflow <= '0;
            r_last   <= LAST_INIT;
            r_ph     <= '0;
            for (int i = 0; i < NREQ; i++) r_pend[i] <= '0;
          end else begin
            CntReset <= 1'b0;
            CntEn    <= w_valid;
            CntSlt   <= w_slt;
            Grant    <= w_gnt;
            if (w_upd_last) r_last <= w_win;
            if (w_valid && w_slt) begin
              Tick1 <= (r_ph == PH_MAX);
              r_ph  <= (r_ph == PH_MAX) ? '0 : r_ph + PH_W'(1);
            end
            for (int i = 0; i < NREQ; i++) begin
              case ({Req[i], w_gnt[i]})
                2'b10: begin
                  if (r_pend[i] == PEND_MAX) Overflow[i] <= 1'b1;
                  else                       r_pend[i]   <= r_pend[i] + PEND_W'(1);
                end
                2'b01:   r_pend[i] <= r_pend[i] - PEND_W'(1);
                default: ;
              endcase
            end
          end
        end
        default: CntReset <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed, table-driven bench for count_sched (NREQ=4, PEND_W=3, DIV1=4).
module tb_count_sched;

  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Clear = 1'b0;
  logic [N-1:0] Req = '0;
  logic [N-1:0] ChanMap = '0;
  logic         CntReset, CntEn, CntSlt, Tick1, Busy;
  logic [N-1:0] Grant, Overflow;

  count_sched #(.NREQ(N), .PEND_W(3), .DIV1(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .ChanMap  (ChanMap),
    .Clear    (Clear),
    .CntReset (CntReset),
    .CntEn    (CntEn),
    .CntSlt   (CntSlt),
    .Grant    (Grant),
    .Tick1    (Tick1),
    .Overflow (Overflow),
    .Busy     (Busy)
  );

  // Clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst, clr;
    logic [3:0] req, cmap;
    logic       crst, en, slt;
    logic [3:0] gnt;
    logic       tick;
    logic [3:0] ovf;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  int         n_total = 0;
  int         n_bad   = 0;

  function automatic vec_t mk(input logic rst, input logic clr, input logic [3:0] req,
                              input logic [3:0] cmap, input logic crst, input logic en,
                              input logic slt, input logic [3:0] gnt, input logic tick,
                              input logic [3:0] ovf, input logic busy);
    vec_t v;
    v.rst = rst; v.clr = clr; v.req = req; v.cmap = cmap;
    v.crst = crst; v.en = en; v.slt = slt; v.gnt = gnt;
    v.tick = tick; v.ovf = ovf; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drivers: inputs change 1ns after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      Reset   = tbl[i].rst;
      Clear   = tbl[i].clr;
      Req     = tbl[i].req;
      ChanMap = tbl[i].cmap;
      step();
      check($sformatf("row%0d_cntreset", i), CntReset, tbl[i].crst);
      check($sformatf("row%0d_cnten", i),    CntEn,    tbl[i].en);
      check($sformatf("row%0d_cntslt", i),   CntSlt,   tbl[i].slt);
      check($sformatf("row%0d_grant", i),    Grant,    tbl[i].gnt);
      check($sformatf("row%0d_tick1", i),    Tick1,    tbl[i].tick);
      check($sformatf("row%0d_overflow", i), Overflow, tbl[i].ovf);
      check($sformatf("row%0d_busy", i),     Busy,     tbl[i].busy);
    end
    Clear = 1'b0;
    Req   = '0;
  endtask

  initial begin : main
    int a_end, b_end;
    int g2, g3;
    logic [3:0] prio_req [8];
    logic [4:0] exp;

    // Reset release and round-robin over a single 4'b1111 pulse
    tbl.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 1, 0, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 1, 0, 4'h2, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 1, 0, 4'h4, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 1, 0, 4'h8, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    // Channel 1: eight back-to-back events on requester 1, Tick1 on issues 4 and 8
    tbl.push_back(mk(0, 0, 4'h2, 4'h2, 0, 0, 0, 4'h0, 0, 4'h0, 1));
    for (int k = 1; k <= 7; k++)
      tbl.push_back(mk(0, 0, 4'h2, 4'h2, 0, 1, 1, 4'h2, (k == 4), 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h2, 0, 1, 1, 4'h2, 1, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h2, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    a_end = tbl.size();
    // Clear from RUN (clears Overflow), requests ignored in S_CLEAR, clear with pending
    tbl.push_back(mk(0, 1, 4'hF, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'hB, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'hA, 4'h0, 0, 1, 0, 4'h1, 0, 4'h0, 1));
    tbl.push_back(mk(0, 1, 4'hE, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    b_end = tbl.size();
    // Reset mid-operation with pending events drops them
    tbl.push_back(mk(0, 0, 4'hF, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(1, 0, 4'hF, 4'h0, 1, 0, 0, 4'h0, 0, 4'h0, 1));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));
    tbl.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 4'h0, 0));

    run_rows(0, a_end);

    // Saturation: requesters 2 and 3 alternate while both are held for 16 cycles
    ChanMap = '0;
    g2 = 0;
    for (int n = 1; n <= 16; n++) begin
      Req = 4'hC;
      step();
      if (Grant[2]) g2++;
      if (n == 14) check("sat_ovf_at14", Overflow, 4'h8);
    end
    check("sat_ovf_at16", Overflow, 4'hC);
    check("sat_hold_grants2", g2, 8);
    Req = '0;
    g2 = 0;
    g3 = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (Grant[2]) g2++;
      if (Grant[3]) g3++;
      if (!Busy) break;
    end
    check("sat_drain_busy", Busy, 0);
    check("sat_drain_grants2", g2, 7);
    check("sat_drain_grants3", g3, 7);
    check("sat_ovf_sticky", Overflow, 4'hC);

    run_rows(a_end, b_end);

    // Requester 0 vs 1 contention; expected {CntEn, Grant} per edge
    prio_req = '{4'h3, 4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
`ifdef COUNT_SCHED_PRIO_EN
    exp_q = '{5'h00, 5'h11, 5'h11, 5'h11, 5'h12, 5'h12, 5'h00, 5'h00};
`else
    exp_q = '{5'h00, 5'h11, 5'h12, 5'h11, 5'h12, 5'h11, 5'h00, 5'h00};
`endif
    for (int k = 0; k < 8; k++) begin
      Req = prio_req[k];
      step();
      exp = exp_q.pop_front();
      check($sformatf("prio_edge%0d", k), {CntEn, Grant}, exp);
    end
    Req = '0;

    run_rows(b_end, tbl.size());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
